// File: rtl/reaction_game_bin2hex_display.sv
// -----------------------------------------------------------------------------
// reaction_game_bin2hex_display
//
// Multi-digit seven-segment driver. A binary value is converted to BCD by a
// sequential double-dabble engine (one input bit per clock). The committed
// result drives NUM_DIGITS active-low seven-segment digits. Leading-zero
// blanking, overflow dashes and whole-display blinking are available.
//
// State table:
//   state | meaning
//   IDLE  | ready for a new value; display shows the last committed result
//   CONV  | shifting the captured value through the BCD accumulator
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   value     unsigned binary value to display (BIN_WIDTH bits)
//   load      start a conversion of value; only honoured while ready=1
//   en        0 blanks every segment immediately; conversion keeps running
//   blank_lz  1 blanks leading zero digits (digit 0 is never blanked)
//   blink     1 makes the whole display blink with period 2*BLINK_DIV
//   ready     1 while idle and able to accept load
//   done      one-cycle pulse after a new result has been committed
//   overflow  1 while the displayed result is >= 10^NUM_DIGITS
//   hex       segments, digit i at hex[7i+6:7i], 0 = segment lit
// -----------------------------------------------------------------------------
module reaction_game_bin2hex_display #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BIN_WIDTH-1:0]      value,
  input  logic                      load,
  input  logic                      en,
  input  logic                      blank_lz,
  input  logic                      blink,
  output logic                      ready,
  output logic                      done,
  output logic                      overflow,
  output logic [NUM_DIGITS*7-1:0]   hex
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t                 state;
  logic [BIN_WIDTH-1:0]   bin_sr;
  logic [BCD_W-1:0]       bcd_acc;
  logic                   sticky;
  logic [CNT_W-1:0]       bit_cnt;

  logic [BCD_W-1:0]       disp_bcd;
  logic                   disp_ovf;
  logic                   valid;

  logic [BLK_W-1:0]       blink_cnt;
  logic                   blink_wrap;
  logic                   phase_on;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W-1:0]       bcd_next;
  logic [BIN_WIDTH-1:0]   bin_next;
  logic                   carry_out;

  // ---------------------------------------------------------------------------
  // Double-dabble step: correct every nibble >= 5, then shift {bcd, bin} left.
  // The bit leaving the top of the BCD field means the value does not fit in
  // NUM_DIGITS decimal digits.
  // ---------------------------------------------------------------------------
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
      end
    end
    carry_out            = bcd_adj[BCD_W-1];
    {bcd_next, bin_next} = {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM. bit_cnt counts remaining shifts; the shift taken while it
  // reads 1 is the last one and commits straight into the display register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      bin_sr   <= '0;
      bcd_acc  <= '0;
      sticky   <= 1'b0;
      bit_cnt  <= '0;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
      valid    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin_sr  <= value;
            bcd_acc <= '0;
            sticky  <= 1'b0;
            bit_cnt <= CNT_W'(BIN_WIDTH);
            ready   <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          bin_sr  <= bin_next;
          bcd_acc <= bcd_next;
          sticky  <= sticky | carry_out;
          bit_cnt <= bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) begin
            disp_bcd <= bcd_next;
            disp_ovf <= sticky | carry_out;
            valid    <= 1'b1;
            done     <= 1'b1;
            ready    <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign overflow = disp_ovf;

  // ---------------------------------------------------------------------------
  // Blink timebase. The counter always runs so the blink rate stays aligned to
  // reset; the phase only toggles while blinking is requested.
  // ---------------------------------------------------------------------------
  assign blink_wrap = (blink_cnt == BLK_W'(BLINK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else begin
      if (blink_wrap) begin
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
      if (!blink) begin
        phase_on <= 1'b1;
      end else if (blink_wrap) begin
        phase_on <= ~phase_on;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Segment decode
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic       lz_run;
  logic [3:0] digit;

  // Walk from the most significant digit down; lz_run stays set while every
  // digit seen so far is zero, so those digits blank. Digit 0 always shows.
  always_comb begin
    hex    = '1;
    lz_run = blank_lz;
    digit  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digit = disp_bcd[4*i +: 4];
      if (lz_run && (digit == 4'd0) && (i != 0)) begin
        hex[7*i +: 7] = SEG_BLANK;
      end else begin
        hex[7*i +: 7] = seg7(digit);
        lz_run        = 1'b0;
      end
    end
    if (disp_ovf) begin
      hex = {NUM_DIGITS{SEG_DASH}};
    end
    if (!en || !valid || !phase_on) begin
      hex = '1;
    end
  end

endmodule

// File: tb/tb_reaction_game_bin2hex_display.sv
module tb_reaction_game_bin2hex_display;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] value;
  logic          load, en, blank_lz, blink;
  logic          ready, done, overflow;
  logic [ND*7-1:0] hex;

  int errors = 0;
  int checks = 0;

  // reference state
  int  disp_val = 0;
  bit  valid_m  = 0;
  int  ec;

  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  reaction_game_bin2hex_display #(
    .NUM_DIGITS(ND), .BIN_WIDTH(BW), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .en(en),
    .blank_lz(blank_lz), .blink(blink), .ready(ready), .done(done),
    .overflow(overflow), .hex(hex)
  );

  always #5 clk = ~clk;

  // edges since reset release, used to predict the blink phase
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;
  end

  function automatic logic [27:0] exp_hex(input int v, input bit blz, input bit en_,
                                          input bit val_, input bit ph);
    logic [27:0] r;
    int p;
    r = '1;
    if (!en_ || !val_ || !ph) return r;
    if (v >= 10000) return {4{7'b0111111}};
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (!(blz && i > 0 && v < p)) r[7*i +: 7] = SEG[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag);
    chk(tag, 32'(hex), 32'(exp_hex(disp_val, blank_lz, en, valid_m, 1'b1)));
  endtask

  // Loads v, checks busy window, commit edge, done pulse and result.
  // inject_at >= 0 presents a second load (value 99) that many cycles in.
  task automatic convert(input int v, input int inject_at);
    @(negedge clk);
    value = 14'(v);
    load  = 1'b1;
    @(negedge clk);                 // load edge k has passed
    load = 1'b0;
    chk("busy_ready", 32'(ready), 32'd0);
    for (int i = 1; i < BW; i++) begin
      if (i == inject_at) begin
        value = 14'd99;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      chk("busy_ready", 32'(ready), 32'd0);
      chk("busy_done", 32'(done), 32'd0);
    end
    load = 1'b0;
    @(negedge clk);                 // after edge k+BW
    disp_val = v;
    valid_m  = 1'b1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_back", 32'(ready), 32'd1);
    chk("overflow", 32'(overflow), 32'(v >= 10000));
    chk_disp("hex_result");
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    int e0, e;
    bit ph;
    rst_n = 1'b0; value = '0; load = 1'b0; en = 1'b1; blank_lz = 1'b0; blink = 1'b0;

    // 1. reset and idle
    repeat (2) @(negedge clk);
    chk("rst_hex", 32'(hex), 32'h0FFF_FFFF);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hex", 32'(hex), 32'h0FFF_FFFF);
    chk("idle_ready", 32'(ready), 32'd1);

    // 2. basic conversion
    convert(1234, -1);
    chk("d1234", 32'(hex), 32'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));

    // 3. leading-zero blanking
    blank_lz = 1'b1;
    convert(7, -1);
    chk("lz7", 32'(hex), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}));
    convert(0, -1);
    chk("lz0", 32'(hex), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}));
    blank_lz = 1'b0;
    #1;
    chk("lz_off_now", 32'(hex), 32'({4{7'b1000000}}));

    // 4. overflow and recovery
    convert(10000, -1);
    chk("ovf_dash", 32'(hex), 32'({4{7'b0111111}}));
    convert(9999, -1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    chk("d9999", 32'(hex), 32'({4{7'b0010000}}));
    convert(16383, -1);

    // 5. load during conversion ignored, then reset mid-conversion
    convert(42, 2);
    chk("d0042", 32'(hex), 32'({7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100}));
    @(negedge clk);
    value = 14'd55;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    valid_m = 1'b0;
    #1;
    chk("mid_rst_hex", 32'(hex), 32'h0FFF_FFFF);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done), 32'd0);
    end
    chk_disp("blank_after_rst");

    // 6. blink, then en gating during a conversion
    convert(1234, -1);
    @(negedge clk);
    e0 = ec;
    blink = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e  = ec;
      ph = (((e / BD) - (e0 / BD)) % 2) == 0;
      chk("blink", 32'(hex), 32'(exp_hex(disp_val, blank_lz, en, valid_m, ph)));
    end
    blink = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("blink_off", 32'(hex), 32'(exp_hex(disp_val, blank_lz, en, valid_m, 1'b1)));
    end
    en = 1'b0;
    #1;
    chk("en_off_now", 32'(hex), 32'h0FFF_FFFF);
    convert(567, -1);
    en = 1'b1;
    #1;
    chk("en_on_567", 32'(hex), 32'({7'b1000000, 7'b0010010, 7'b0000010, 7'b1111000}));

    // randomized values against the reference model
    for (int i = 0; i < 10; i++) begin
      blank_lz = 1'($urandom_range(0, 1));
      convert(int'($urandom_range(0, 16383)), -1);
      blank_lz = ~blank_lz;
      #1;
      chk_disp("rand_lz_flip");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_game_bin2hex_display.md
Name: reaction_game_bin2hex_display

Overview:
Multi-digit seven-segment display driver and the parametrised successor to the single-digit hex decoder. It accepts a binary value and converts it to BCD with a sequential double-dabble engine, one bit per clock. It drives NUM_DIGITS active-low seven-segment outputs with optional leading-zero blanking, overflow indication and blinking. It sits between the reaction-time counter / score logic and the board HEX displays.

Parameters:
NUM_DIGITS, 4, number of decimal digits driven (1..8).
BIN_WIDTH, 14, width of binary input value (1..32).
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
value  input  BIN_WIDTH  unsigned binary value to display.
load  input  1  request conversion of value; sampled only when ready=1.
en  input  1  0 forces every segment off (combinational); conversion unaffected.
blank_lz  input  1  1 enables leading-zero blanking.
blink  input  1  1 enables blinking of the whole display.
ready  output  1  1 when idle and able to accept load.
done  output  1  one-cycle pulse when a new result is committed to the display.
overflow  output  1  1 while the displayed result is an overflow (value >= 10^NUM_DIGITS).
hex  output  NUM_DIGITS*7  segments; digit i at hex[7i+6:7i], digit 0 least significant; bit 0=top, 1=upper-right, 2=lower-right, 3=bottom, 4=lower-left, 5=upper-left, 6=middle; 0 = segment lit.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ready=1; done=0; overflow=0.
  - Display register cleared; valid flag=0, so hex = all ones (blank) until the first commit.
  - Blink counter=0; blink phase=on.
- FSM states: IDLE, CONV.
  - IDLE: ready=1. If load=1 at edge k: capture value into the shift register, clear the BCD accumulator and the overflow-sticky bit, set bit counter=BIN_WIDTH, go to CONV. ready=0 from edge k.
  - CONV: on each edge, add 3 to every BCD nibble >=5, then shift {bcd, bin} left by one. The bit shifted out of the BCD MSB (bit 4*NUM_DIGITS-1) sets the overflow-sticky bit. Decrement the counter.
  - Final shift occurs at edge k+BIN_WIDTH. At that edge: write the BCD result and sticky bit into the display register, set valid=1, pulse done=1 for the following cycle, return to IDLE (ready=1).
  - Load-to-display latency is exactly BIN_WIDTH cycles; throughput is one conversion per BIN_WIDTH+1 cycles if load is held.
- load while ready=0 is ignored; no queuing. The value input is not re-sampled during CONV.
- Reset mid-conversion: abort immediately; all outputs return to reset values; no done pulse.
- Digit decode, per nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any non-BCD nibble = 1111111.
- Overflow: while the display register's overflow=1, every digit shows dash 0111111 and the overflow output is 1. It is cleared by the next non-overflowing commit.
- Leading-zero blanking, when blank_lz=1 and not in overflow: digit i>0 shows 1111111 if it and all higher digits are zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Blink:
  - A free-running counter wraps at BLINK_DIV-1; on each wrap the phase toggles when blink=1.
  - When blink=0, phase is forced to on and the counter keeps running.
  - Phase off → hex all ones.
- Output priority, highest first: en=0 → blank; valid=0 → blank; blink phase off → blank; overflow → dashes; else decoded digits with blanking.
- hex is a combinational function of registered state plus en. en and blank_lz take effect in the same cycle.

Test Plan:
1. Reset, hold idle → hex=all 1s, ready=1, done=0, overflow=0.
2. Defaults, load value=1234 → ready=0 for 14 cycles; done pulses once; digits3..0 = 1111001, 0100100, 0110000, 0011001; ready=1.
3. blank_lz=1, load 7 → digit0=1111000, digits1..3=1111111. Then load 0 → digit0=1000000. Then blank_lz=0 → digits1..3=1000000 the same cycle.
4. Load 10000 → overflow=1, all digits 0111111. Then load 9999 → overflow=0, all digits 0010000.
5. Load 42, assert load with 99 two cycles later → ignored, display shows 0042. Next, load 55 and pulse rst_n low at cycle 5 → hex blank, ready=1, no done.
6. BLINK_DIV=4, blink=1 after displaying 1234 → hex alternates value/blank every 4 cycles; blink=0 → steady value; en=0 → all 1s in the same cycle, and a conversion started meanwhile still completes with done.
